hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the ID stage and drives the enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch squashes and data-memory wait states. It keeps an internal shadow of the ID/EX load destination, a wait-state FSM, a memory-timeout watchdog and saturating performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 39 +++
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_ctrl_src_reg_decode.sv | 28 ++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: RV32I opcodes,
// the wait-state FSM encoding and the source-register usage lookup.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic {
        RUN,
        WAIT
    } ctrl_state_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
    } src_use_t;

    function automatic src_use_t src_uses(input logic [6:0] opcode);
        src_use_t u;
        u = '0;
        case (opcode)
            OP_LOAD, OP_OPIMM: begin
                u.uses_rs1 = 1'b1;
            end
            OP_STORE, OP_BRANCH, OP_OP: begin
                u.uses_rs1 = 1'b1;
                u.uses_rs2 = 1'b1;
            end
            default: begin
                u = '0;
            end
        endcase
        return u;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID-stage inputs, pipeline register controls and status counters
// exchanged between the core datapath and the hazard controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      id_inst;
    logic             id_valid;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             dmem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             exmem_en;
    logic             memwb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_inst, id_valid, ex_branch_taken, mem_req, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               memwb_bubble, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_inst, id_valid, ex_branch_taken, mem_req, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               memwb_bubble, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_src_reg_decode.sv
// Extracts register fields and source-usage flags from an RV32I instruction;
// also used by the forwarding unit.
module src_reg_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        is_load
);
    src_use_t use_flags;
    logic     unused_bits;

    assign rs1       = inst[19:15];
    assign rs2       = inst[24:20];
    assign rd        = inst[11:7];
    assign use_flags = src_uses(inst[6:0]);
    assign uses_rs1  = use_flags.uses_rs1;
    assign uses_rs2  = use_flags.uses_rs2;
    assign is_load   = (inst[6:0] == OP_LOAD);

    // funct3/funct7 play no part in hazard detection
    assign unused_bits = ^{inst[31:25], inst[14:12]};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use, taken-branch and dmem
// wait hazards, with a wait watchdog and saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int              WC_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

    logic [4:0]       rs1, rs2, rd;
    logic             uses_rs1, uses_rs2, is_load;
    ctrl_state_t      state_q, state_d;
    logic             ex_is_load_q, ex_is_load_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_wait, load_use, branch_act, stall_act;
    logic             pc_en, ifid_en, ifid_flush, idex_en;
    logic             idex_bubble, exmem_en, memwb_bubble;

    src_reg_decode u_decode (
        .inst     (bus.id_inst),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .is_load  (is_load)
    );

    assign mem_wait   = bus.mem_req & ~bus.dmem_ready;
    assign load_use   = bus.id_valid & ex_is_load_q & (ex_rd_q != 5'd0) &
                        ((uses_rs1 & (rs1 == ex_rd_q)) | (uses_rs2 & (rs2 == ex_rd_q)));
    assign branch_act = bus.ex_branch_taken & ~mem_wait;
    // A taken branch squashes the dependent instruction, so it never stalls
    assign stall_act  = mem_wait | (load_use & ~bus.ex_branch_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mem_wait) state_d = WAIT;
            WAIT:    if (bus.dmem_ready || !bus.mem_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_bubble  = 1'b1;
        end
    end

    always_comb begin
        ex_is_load_d = ex_is_load_q;
        ex_rd_d      = ex_rd_q;
        if (idex_en) begin
            if (idex_bubble || !bus.id_valid) begin
                ex_is_load_d = 1'b0;
            end else begin
                ex_is_load_d = is_load;
                ex_rd_d      = rd;
            end
        end

        // A fresh wait episode always restarts the watchdog from one
        wait_cnt_d = '0;
        if (mem_wait) begin
            if (state_q == RUN) begin
                wait_cnt_d = WC_W'(1);
            end else if (wait_cnt_q != WC_MAX) begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == WC_MAX);

        stall_cnt_d = stall_cnt_q;
        if (stall_act && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (branch_act && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_is_load_q  <= 1'b0;
            ex_rd_q       <= 5'd0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_is_load_q  <= ex_is_load_d;
            ex_rd_q       <= ex_rd_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_en      = idex_en;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_en     = exmem_en;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.mem_timeout  = mem_timeout_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: vectors push expected responses,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}
    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_MW   = 7'b0000001;
    localparam logic [6:0] C_RST  = 7'b0010101;

    typedef struct {
        int               id;
        logic [6:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    logic clk;
    logic rst_n;
    logic [31:0] nop, lw5, lw0, add652, add600, addi675, sw5;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, OP_OP};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endfunction

    // Drive one cycle of inputs and queue the response expected in that cycle
    task automatic applyStimulus(input logic rst_v, input logic [31:0] inst,
                                 input logic valid, input logic br,
                                 input logic req, input logic rdy,
                                 input logic [6:0] ctrl, input int stall,
                                 input int flush, input logic tmo);
        exp_t e;
        rst_n               = rst_v;
        hif.id_inst         = inst;
        hif.id_valid        = valid;
        hif.ex_branch_taken = br;
        hif.mem_req         = req;
        hif.dmem_ready      = rdy;
        e.id    = vec_id;
        e.ctrl  = ctrl;
        e.stall = CNT_W'(stall);
        e.flush = CNT_W'(flush);
        e.tmo   = tmo;
        exp_q.push_back(e);
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0] act;
        act = {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
               hif.idex_bubble, hif.exmem_en, hif.memwb_bubble};
        checks++;
        if (act !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL ctrl vec %0d: got %b expected %b", e.id, act, e.ctrl);
        end
        checks++;
        if (hif.stall_cnt !== e.stall) begin
            errors++;
            $display("[TB] FAIL stall_cnt vec %0d: got %0d expected %0d", e.id, hif.stall_cnt, e.stall);
        end
        checks++;
        if (hif.flush_cnt !== e.flush) begin
            errors++;
            $display("[TB] FAIL flush_cnt vec %0d: got %0d expected %0d", e.id, hif.flush_cnt, e.flush);
        end
        checks++;
        if (hif.mem_timeout !== e.tmo) begin
            errors++;
            $display("[TB] FAIL mem_timeout vec %0d: got %b expected %b", e.id, hif.mem_timeout, e.tmo);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        nop     = 32'h0000_0013;
        lw5     = enc_i(OP_LOAD, 3'b010, 5'd5, 5'd1, 12'd0);
        lw0     = enc_i(OP_LOAD, 3'b010, 5'd0, 5'd1, 12'd0);
        add652  = enc_r(5'd6, 5'd5, 5'd2);
        add600  = enc_r(5'd6, 5'd0, 5'd0);
        addi675 = enc_i(OP_OPIMM, 3'b000, 5'd6, 5'd7, 12'd5);
        sw5     = enc_s(5'd9, 5'd5, 12'd0);

        rst_n               = 1'b0;
        hif.id_inst         = nop;
        hif.id_valid        = 1'b0;
        hif.ex_branch_taken = 1'b0;
        hif.mem_req         = 1'b0;
        hif.dmem_ready      = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, then idle
        applyStimulus(0, nop, 0, 0, 0, 0, C_RST,  0, 0, 0);
        applyStimulus(1, nop, 0, 0, 0, 0, C_NORM, 0, 0, 0);

        // Load-use: one stall cycle, then normal
        applyStimulus(1, lw5,    1, 0, 0, 0, C_NORM, 0, 0, 0);
        applyStimulus(1, add652, 1, 0, 0, 0, C_LU,   0, 0, 0);
        applyStimulus(1, add652, 1, 0, 0, 0, C_NORM, 1, 0, 0);

        // x0 destination and an unused rs2 field never stall
        applyStimulus(1, lw0,     1, 0, 0, 0, C_NORM, 1, 0, 0);
        applyStimulus(1, add600,  1, 0, 0, 0, C_NORM, 1, 0, 0);
        applyStimulus(1, lw5,     1, 0, 0, 0, C_NORM, 1, 0, 0);
        applyStimulus(1, addi675, 1, 0, 0, 0, C_NORM, 1, 0, 0);

        // Store consuming the load result through rs2
        applyStimulus(1, lw5, 1, 0, 0, 0, C_NORM, 1, 0, 0);
        applyStimulus(1, sw5, 1, 0, 0, 0, C_LU,   1, 0, 0);
        applyStimulus(1, sw5, 1, 0, 0, 0, C_NORM, 2, 0, 0);

        // Taken branch, alone and overriding a load-use
        applyStimulus(1, nop,    1, 1, 0, 0, C_BR,   2, 0, 0);
        applyStimulus(1, lw5,    1, 0, 0, 0, C_NORM, 2, 1, 0);
        applyStimulus(1, add652, 1, 1, 0, 0, C_BR,   2, 1, 0);
        applyStimulus(1, add652, 1, 0, 0, 0, C_NORM, 2, 2, 0);

        // Three-cycle memory wait
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, nop, 1, 0, 1, 0, C_MW, 2 + i, 2, 0);
        end
        applyStimulus(1, nop, 1, 0, 1, 1, C_NORM, 5, 2, 0);
        applyStimulus(1, nop, 1, 0, 0, 0, C_NORM, 5, 2, 0);

        // Branch held through a two-cycle wait, flushed once ready
        applyStimulus(1, nop, 1, 1, 1, 0, C_MW,   5, 2, 0);
        applyStimulus(1, nop, 1, 1, 1, 0, C_MW,   6, 2, 0);
        applyStimulus(1, nop, 1, 1, 1, 1, C_BR,   7, 2, 0);
        applyStimulus(1, nop, 1, 0, 0, 0, C_NORM, 7, 3, 0);

        // Watchdog trips after the fourth wait cycle and stays set
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, nop, 1, 0, 1, 0, C_MW, 7 + i, 3, (i >= 4) ? 1'b1 : 1'b0);
        end
        // Stall counter saturates at all ones
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, nop, 1, 0, 1, 0, C_MW, (13 + i > 15) ? 15 : 13 + i, 3, 1);
        end

        // Reset mid-wait clears everything and restarts cleanly
        applyStimulus(0, nop, 1, 0, 1, 0, C_RST,  0, 0, 0);
        applyStimulus(1, nop, 1, 0, 0, 0, C_NORM, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, nop, 1, 0, 1, 0, C_MW, i, 0, 0);
        end
        applyStimulus(1, nop, 1, 0, 1, 1, C_NORM, 3, 0, 0);
        applyStimulus(1, nop, 1, 0, 0, 0, C_NORM, 3, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
